// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants: framing bytes, CRC-32 parameters,
// receive FSM state encodings and the byte-wise reflected CRC-32 update.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
    localparam logic [31:0] ETH_CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] ETH_CRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] ETH_CRC_RESIDUE   = 32'hDEBB_20E3;

    localparam logic [1:0] S_PREAMBLE = 2'd0;
    localparam logic [1:0] S_PAYLOAD  = 2'd1;
    localparam logic [1:0] S_DROP     = 2'd2;

    // LSB-first CRC-32 over one byte, no final inversion.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_rx_fcs_check.sv
// Strips preamble/SFD and FCS from a buffered receive byte stream, checks the
// CRC-32 residue and flags the last payload byte; keeps per-frame statistics.
module eth_rx_fcs_check
    import eth_pkg::*;
#(
    parameter int PREAMBLE_MAX_LEN = 7,
    parameter int COUNTER_WIDTH    = 16
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [7:0]               Input_data,
    input  logic                     Input_valid,
    input  logic                     Input_last,
    output logic                     Input_ready,
    output logic [7:0]               Output_data,
    output logic                     Output_valid,
    output logic                     Output_last,
    output logic                     Output_fcs_ok,
    input  logic                     Output_ready,
    output logic [COUNTER_WIDTH-1:0] Count_good,
    output logic [COUNTER_WIDTH-1:0] Count_bad_fcs,
    output logic [COUNTER_WIDTH-1:0] Count_dropped,
    output logic [1:0]               Dbg_state
);

    localparam int PW = $clog2(PREAMBLE_MAX_LEN + 1) + 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(PREAMBLE_MAX_LEN);

    logic [1:0]       state;
    logic [PW-1:0]    pcnt;
    logic [2:0]       hold_cnt;
    logic [3:0][7:0]  hold;
    logic [31:0]      crc;
    logic [31:0]      crc_nxt;
    logic             accept;
    logic             emit;
    logic             fcs_match;
    logic             inc_good;
    logic             inc_bad;
    logic             inc_drop;

    // Handshake: a beat moves when valid && ready on a rising edge. Input is
    // accepted only when the single output register is empty or draining, and
    // never while reset is asserted.
    assign Input_ready = Rst_n && (!Output_valid || Output_ready);
    assign accept      = Input_valid && Input_ready;
    assign crc_nxt     = crc32_next(crc, Input_data);
    assign fcs_match   = (crc_nxt == ETH_CRC_RESIDUE);
    assign emit        = accept && (state == S_PAYLOAD) && (hold_cnt == 3'd4);
    assign Dbg_state   = state;

    always_comb begin
        inc_good = 1'b0;
        inc_bad  = 1'b0;
        inc_drop = 1'b0;
        if (accept && Input_last) begin
            case (state)
                S_PAYLOAD: begin
                    if (hold_cnt != 3'd4) inc_drop = 1'b1;
                    else if (fcs_match)   inc_good = 1'b1;
                    else                  inc_bad  = 1'b1;
                end
                default: inc_drop = 1'b1;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= S_PREAMBLE;
            pcnt     <= '0;
            hold_cnt <= '0;
            hold     <= '0;
            crc      <= ETH_CRC_INIT;
        end else if (accept) begin
            case (state)
                S_PREAMBLE: begin
                    if (Input_last) begin
                        pcnt <= '0;
                    end else if (Input_data == ETH_PREAMBLE_BYTE) begin
                        if (pcnt == PCNT_MAX) begin
                            state <= S_DROP;
                            pcnt  <= '0;
                        end else begin
                            pcnt <= pcnt + 1'b1;
                        end
                    end else if (Input_data == ETH_SFD_BYTE && pcnt != '0) begin
                        state    <= S_PAYLOAD;
                        pcnt     <= '0;
                        crc      <= ETH_CRC_INIT;
                        hold_cnt <= '0;
                    end else begin
                        state <= S_DROP;
                        pcnt  <= '0;
                    end
                end
                S_PAYLOAD: begin
                    crc  <= crc_nxt;
                    hold <= {hold[2:0], Input_data};
                    if (hold_cnt != 3'd4) hold_cnt <= hold_cnt + 1'b1;
                    if (Input_last) state <= S_PREAMBLE;
                end
                S_DROP: begin
                    if (Input_last) state <= S_PREAMBLE;
                end
                default: state <= S_PREAMBLE;
            endcase
        end
    end

    // hold[3] is the byte accepted four bytes ago; the last four bytes are FCS.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Output_data   <= '0;
            Output_valid  <= 1'b0;
            Output_last   <= 1'b0;
            Output_fcs_ok <= 1'b0;
        end else if (emit) begin
            Output_data   <= hold[3];
            Output_valid  <= 1'b1;
            Output_last   <= Input_last;
            Output_fcs_ok <= Input_last && fcs_match;
        end else if (Output_ready) begin
            Output_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Count_good    <= '0;
            Count_bad_fcs <= '0;
            Count_dropped <= '0;
        end else begin
            if (inc_good && Count_good != '1)       Count_good    <= Count_good + 1'b1;
            if (inc_bad  && Count_bad_fcs != '1)    Count_bad_fcs <= Count_bad_fcs + 1'b1;
            if (inc_drop && Count_dropped != '1)    Count_dropped <= Count_dropped + 1'b1;
        end
    end

endmodule
